ahb3lite_sram_arbiter: RTL and testbench
========================================

Name: ahb3lite_sram_arbiter

Overview:
- Two-requester AHB-Lite master that shares one ahb3lite_sram1rw slave between two simple single-transfer request ports.
- Round-robin arbitration between the ports.
- Drives AHB-Lite SINGLE transfers with overlapping address and data phases, and returns each response, in order, to the port that issued it.
- Sits between the client logic and the SRAM slave, inside the same interface-level wrapper.

Parameters:
- HADDR_SIZE, 8: address width (matches the slave).
- HDATA_SIZE, 32: data width (matches the slave).

Ports:
- HCLK  in  1  clock.
- HRESETn  in  1  asynchronous active-low reset.
- req_valid  in  2  request present, one bit per port (index 0, 1).
- req_ready  out  2  request accepted this cycle (combinational).
- req_write  in  2  1 = write, 0 = read.
- req_size  in  2x3  HSIZE per port; allowed values 000, 001, 010.
- req_addr  in  2xHADDR_SIZE  byte address per port.
- req_wdata  in  2xHDATA_SIZE  write data per port; the requester replicates byte lanes.
- rsp_valid  out  2  one-cycle completion pulse per port.
- rsp_rdata  out  HDATA_SIZE  read data, shared, valid with rsp_valid.
- rsp_err  out  1  HRESP seen for the transfer, valid with rsp_valid.
- HSEL  out  1  to slave.
- HADDR  out  HADDR_SIZE  to slave.
- HWRITE  out  1  to slave.
- HSIZE  out  3  to slave.
- HBURST  out  3  to slave; constant 000 (SINGLE).
- HPROT  out  4  to slave; constant 0011.
- HTRANS  out  2  to slave; IDLE 00 or NONSEQ 10 only.
- HWDATA  out  HDATA_SIZE  to slave.
- HREADY  out  1  to slave; equals HREADYOUT combinationally.
- HRDATA  in  HDATA_SIZE  from slave.
- HREADYOUT  in  1  from slave.
- HRESP  in  1  from slave.

Behaviour:
- Reset (HRESETn=0, asynchronous) forces:
  - HSEL=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=010, HWDATA=0.
  - rsp_valid=00, rsp_rdata=0, rsp_err=0, req_ready=00.
  - Round-robin pointer = port 0.
  - Any in-flight transfer is dropped with no response. This also applies to reset asserted mid-operation.
- Internal state:
  - Address slot: valid, owner, addr, write, size, wdata.
  - Data slot: valid, owner, write, wdata.
  - The two slots form a 2-stage pipeline.
- Address slot can load when it is empty, or when it is vacating this cycle (valid & HREADYOUT=1 & HRESP=0).
- Arbitration, evaluated when the address slot can load:
  - The grant goes to the pointer port if its req_valid=1, else to the other port.
  - req_ready is high for the granted port only; the handshake completes on req_valid & req_ready.
  - On a grant the pointer moves to the non-granted port.
- Loaded fields are registered into the address slot.
- HSEL = HTRANS[1] = addr slot valid & !HRESP, combinational gating. This cancels the pending address phase during both cycles of an ERROR response; the transfer stays queued and is reissued.
- Address phase completes on HREADYOUT=1 with NONSEQ driven:
  - Its fields move into the data slot.
  - HWDATA is registered from the moved wdata.
- Data phase completes on HREADYOUT=1 with the data slot valid:
  - Next cycle: rsp_valid[owner]=1 for one cycle.
  - rsp_rdata = HRDATA for reads, 0 for writes.
  - rsp_err = HRESP.
- Wait states: while HREADYOUT=0, all HADDR/HTRANS/control and HWDATA outputs hold, and req_ready=00.
- Simultaneous events: the address slot vacating and a new request loading in the same cycle is allowed.
  - Zero-wait back-to-back throughput is one transfer per cycle.
- Latency: handshake in cycle N → NONSEQ in N+1 → data phase N+2 → rsp_valid in N+3 (no wait states).
- No transfer queued: HTRANS=IDLE, HSEL=0, address/control hold their last value.
- Alignment is the requester's responsibility; HADDR is driven unmodified.
- Responses always return in issue order; at most 2 transfers are outstanding.

Decomposition:
- Package ahb3lite_pkg holds:
  - HTRANS_IDLE/NONSEQ and HBURST_SINGLE constants.
  - HSIZE_B8/B16/B32 constants.
  - HPROT_DATA_PRIV constant (0011).
  - A typedef for the slot record (valid, owner, addr, write, size, wdata).
- One sub-module: ahb_rr_arb2, the 2-way round-robin grant logic (pointer register plus combinational grant).

Test Plan:
- Single write, then read:
  - Port 0 writes 0xDEADBEEF to 0x10 (size 010); port 0 then reads 0x10.
  - Expect rsp_valid[0] at N+3 for each transfer, read rsp_rdata=0xDEADBEEF, rsp_err=0.
- Contention:
  - Both ports hold req_valid for 4 cycles with distinct addresses 0x20/0x40.
  - Expect grants alternating 0,1,0,1.
  - Expect HTRANS NONSEQ on 4 consecutive cycles and responses in the same order.
- Wait states:
  - Slave model stubs HREADYOUT=0 for 2 cycles during the data phase of a read of 0x08.
  - Expect HADDR/HTRANS of the pipelined next request to hold, req_ready=00 during the stall, rsp_valid delayed by 2 cycles.
- Byte write:
  - Port 1 writes size 000 to 0x03 with wdata 0xAAAAAAAA over word 0x00 previously holding 0x11223344.
  - Read back 0x00 → 0xAA223344.
- Error response:
  - Force HRESP=1 for 2 cycles (HREADYOUT 0 then 1) on a transfer with a pipelined successor.
  - Expect HTRANS=IDLE in both cycles, rsp_err=1 for the failing transfer, successor reissued and completing with rsp_err=0.
- Reset mid-transfer:
  - Assert HRESETn=0 during a data phase.
  - Expect all outputs at reset values immediately, no rsp_valid for the dropped transfer, grant pointer at port 0 after release.

Source files
------------

// File: rtl/ahb3lite_pkg.sv
// Shared AHB-Lite encodings and the request slot record used by the SRAM arbiter.
package ahb3lite_pkg;
  localparam logic [1:0] HTRANS_IDLE     = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ   = 2'b10;
  localparam logic [2:0] HBURST_SINGLE   = 3'b000;
  localparam logic [2:0] HSIZE_B8        = 3'b000;
  localparam logic [2:0] HSIZE_B16       = 3'b001;
  localparam logic [2:0] HSIZE_B32       = 3'b010;
  localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

  // Slot record is sized for the ahb3lite_sram1rw slave it fronts.
  localparam int SLOT_AW = 8;
  localparam int SLOT_DW = 32;

  typedef struct packed {
    logic               valid;
    logic               owner;
    logic [SLOT_AW-1:0] addr;
    logic               write;
    logic [2:0]         size;
    logic [SLOT_DW-1:0] wdata;
  } slot_t;
endpackage

// File: rtl/ahb_rr_arb2.sv
// Two-way round-robin grant: pointer port wins if requesting, else the other port.
module ahb_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic       gnt
);
  logic ptr;

  assign gnt = req[ptr] ? ptr : ~ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= 1'b0;
    else if (adv) ptr <= ~gnt;
  end
endmodule

// File: rtl/ahb3lite_sram_arbiter.sv
// Two-port AHB-Lite master sharing one SRAM slave; address/data slots form a
// 2-deep pipeline and responses return in issue order to the issuing port.
module ahb3lite_sram_arbiter
  import ahb3lite_pkg::*;
#(
  parameter int HADDR_SIZE = SLOT_AW,
  parameter int HDATA_SIZE = SLOT_DW
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [1:0]                 req_write,
  input  logic [1:0][2:0]            req_size,
  input  logic [1:0][HADDR_SIZE-1:0] req_addr,
  input  logic [1:0][HDATA_SIZE-1:0] req_wdata,
  output logic [1:0]                 rsp_valid,
  output logic [HDATA_SIZE-1:0]      rsp_rdata,
  output logic                       rsp_err,
  output logic                       HSEL,
  output logic [HADDR_SIZE-1:0]      HADDR,
  output logic                       HWRITE,
  output logic [2:0]                 HSIZE,
  output logic [2:0]                 HBURST,
  output logic [3:0]                 HPROT,
  output logic [1:0]                 HTRANS,
  output logic [HDATA_SIZE-1:0]      HWDATA,
  output logic                       HREADY,
  input  logic [HDATA_SIZE-1:0]      HRDATA,
  input  logic                       HREADYOUT,
  input  logic                       HRESP
);
  slot_t a_slot;
  logic  d_valid, d_owner, d_write;
  logic  addr_vacate, can_load, gnt, take;

  ahb_rr_arb2 u_arb (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .req   (req_valid),
    .adv   (take),
    .gnt   (gnt)
  );

  // An errored address phase is not vacating, so the slot holds and reissues.
  assign addr_vacate = a_slot.valid & HREADYOUT & ~HRESP;
  assign can_load    = HRESETn & HREADYOUT & (~a_slot.valid | ~HRESP);
  assign req_ready   = can_load ? (gnt ? 2'b10 : 2'b01) : 2'b00;
  assign take        = |(req_valid & req_ready);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_slot <= '{valid: 1'b0, owner: 1'b0, addr: '0, write: 1'b0,
                  size: HSIZE_B32, wdata: '0};
    end else if (take) begin
      a_slot <= '{valid: 1'b1, owner: gnt, addr: req_addr[gnt],
                  write: req_write[gnt], size: req_size[gnt],
                  wdata: req_wdata[gnt]};
    end else if (addr_vacate) begin
      a_slot.valid <= 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_valid   <= 1'b0;
      d_owner   <= 1'b0;
      d_write   <= 1'b0;
      HWDATA    <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 2'b00;
      if (HREADYOUT) begin
        if (d_valid) begin
          rsp_valid[d_owner] <= 1'b1;
          rsp_rdata          <= d_write ? '0 : HRDATA;
          rsp_err            <= HRESP;
        end
        d_valid <= addr_vacate;
        if (addr_vacate) begin
          d_owner <= a_slot.owner;
          d_write <= a_slot.write;
          HWDATA  <= a_slot.wdata;
        end
      end
    end
  end

  // HRESP gates the address phase off during both cycles of an error response.
  assign HSEL   = a_slot.valid & ~HRESP;
  assign HTRANS = HSEL ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR  = a_slot.addr;
  assign HWRITE = a_slot.write;
  assign HSIZE  = a_slot.size;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_DATA_PRIV;
  assign HREADY = HREADYOUT;
endmodule

// File: tb/tb_ahb3lite_sram_arbiter.sv
// Directed bench: cycle tables of {requests, slave stall/error, expected outputs}
// against a small behavioural SRAM slave, plus hand-written reset sequences.
module tb_ahb3lite_sram_arbiter;
  logic             HCLK = 1'b0;
  logic             HRESETn = 1'b0;
  logic [1:0]       req_valid, req_ready, req_write;
  logic [1:0][2:0]  req_size;
  logic [1:0][7:0]  req_addr;
  logic [1:0][31:0] req_wdata;
  logic [1:0]       rsp_valid;
  logic [31:0]      rsp_rdata;
  logic             rsp_err;
  logic             HSEL, HWRITE, HREADY, HREADYOUT, HRESP;
  logic [7:0]       HADDR;
  logic [2:0]       HSIZE, HBURST;
  logic [3:0]       HPROT;
  logic [1:0]       HTRANS;
  logic [31:0]      HWDATA, HRDATA;

  ahb3lite_sram_arbiter #(.HADDR_SIZE(8), .HDATA_SIZE(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HWDATA(HWDATA),
    .HREADY(HREADY), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // ---------------- behavioural SRAM slave ----------------
  logic        stall = 1'b0;
  logic [1:0]  eph = 2'd0;   // 1: first error cycle, 2: second error cycle
  logic        dp_v, dp_w, loaded = 1'b0;
  logic [7:0]  dp_a;
  logic [2:0]  dp_sz;
  logic [31:0] mem [64];

  assign HREADYOUT = !stall && (eph != 2'd1);
  assign HRESP     = (eph != 2'd0);
  assign HRDATA    = dp_v ? mem[dp_a[7:2]] : 32'h0;

  function automatic logic [31:0] wmerge(logic [31:0] old, logic [31:0] wd,
                                         logic [7:0] a, logic [2:0] sz);
    logic [31:0] m;
    if (sz == 3'd0)      m = 32'hFF << (8 * a[1:0]);
    else if (sz == 3'd1) m = a[1] ? 32'hFFFF0000 : 32'h0000FFFF;
    else                 m = 32'hFFFFFFFF;
    return (old & ~m) | (wd & m);
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_v <= 1'b0;
      if (!loaded) begin
        for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
        mem[0]  <= 32'h11223344;
        mem[2]  <= 32'h08080808;
        mem[3]  <= 32'h0C0C0C0C;
        mem[8]  <= 32'hA0A0A0A0;
        mem[16] <= 32'hB0B0B0B0;
        loaded  <= 1'b1;
      end
    end else if (HREADYOUT) begin
      if (dp_v && dp_w && !HRESP) mem[dp_a[7:2]] <= wmerge(mem[dp_a[7:2]], HWDATA, dp_a, dp_sz);
      dp_v  <= HSEL && (HTRANS == 2'b10) && HREADY;
      dp_a  <= HADDR;
      dp_w  <= HWRITE;
      dp_sz <= HSIZE;
    end
  end

  // ---------------- vector tables ----------------
  typedef struct packed {
    logic v; logic w; logic [2:0] sz; logic [7:0] a; logic [31:0] d;
  } req_t;

  typedef struct packed {
    req_t r0; req_t r1;
    logic st; logic [1:0] ep;
    logic [2:0] rdy;            // {check, value}
    logic [1:0] tr;
    logic [8:0] ea;             // {check, HADDR}
    logic [1:0] rsp; logic [31:0] rd; logic er;
  } vec_t;

  localparam req_t NO = '0;
  localparam logic [2:0] RX = 3'b000, R00 = 3'b100, R01 = 3'b101, R10 = 3'b110;
  localparam logic [1:0] I = 2'b00, N = 2'b10;
  localparam logic [8:0] AX = 9'h000;

  function automatic req_t RD(logic [7:0] a);
    return '{v: 1'b1, w: 1'b0, sz: 3'd2, a: a, d: 32'h0};
  endfunction
  function automatic req_t WR(logic [7:0] a, logic [31:0] d, logic [2:0] sz);
    return '{v: 1'b1, w: 1'b1, sz: sz, a: a, d: d};
  endfunction
  function automatic logic [8:0] A(logic [7:0] a);
    return {1'b1, a};
  endfunction
  function automatic vec_t V(req_t r0, req_t r1, logic st, logic [1:0] ep,
                             logic [2:0] rdy, logic [1:0] tr, logic [8:0] ea,
                             logic [1:0] rsp, logic [31:0] rd, logic er);
    return '{r0: r0, r1: r1, st: st, ep: ep, rdy: rdy, tr: tr, ea: ea,
             rsp: rsp, rd: rd, er: er};
  endfunction

  vec_t tbl[$];
  int   n_vec = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic apply(req_t r0, req_t r1);
    req_valid    = {r1.v, r0.v};
    req_write    = {r1.w, r0.w};
    req_size[0]  = r0.sz; req_size[1]  = r1.sz;
    req_addr[0]  = r0.a;  req_addr[1]  = r1.a;
    req_wdata[0] = r0.d;  req_wdata[1] = r1.d;
  endtask

  task automatic run_tbl(string sec);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge HCLK);
      apply(tbl[i].r0, tbl[i].r1);
      stall = tbl[i].st;
      eph   = tbl[i].ep;
      #1;
      chk($sformatf("%s[%0d] htrans", sec, i), 32'(HTRANS), 32'(tbl[i].tr));
      chk($sformatf("%s[%0d] hsel", sec, i), 32'(HSEL), 32'(tbl[i].tr[1]));
      chk($sformatf("%s[%0d] rsp_valid", sec, i), 32'(rsp_valid), 32'(tbl[i].rsp));
      if (tbl[i].rdy[2])
        chk($sformatf("%s[%0d] req_ready", sec, i), 32'(req_ready), 32'(tbl[i].rdy[1:0]));
      if (tbl[i].ea[8])
        chk($sformatf("%s[%0d] haddr", sec, i), 32'(HADDR), 32'(tbl[i].ea[7:0]));
      if (tbl[i].rsp != 2'b00) begin
        chk($sformatf("%s[%0d] rsp_rdata", sec, i), rsp_rdata, tbl[i].rd);
        chk($sformatf("%s[%0d] rsp_err", sec, i), 32'(rsp_err), 32'(tbl[i].er));
      end
    end
    tbl.delete();
  endtask

  task automatic chk_reset(string sec);
    chk({sec, " hsel"}, 32'(HSEL), 32'h0);
    chk({sec, " htrans"}, 32'(HTRANS), 32'h0);
    chk({sec, " haddr"}, 32'(HADDR), 32'h0);
    chk({sec, " hwrite"}, 32'(HWRITE), 32'h0);
    chk({sec, " hsize"}, 32'(HSIZE), 32'h2);
    chk({sec, " hwdata"}, HWDATA, 32'h0);
    chk({sec, " hburst"}, 32'(HBURST), 32'h0);
    chk({sec, " hprot"}, 32'(HPROT), 32'h3);
    chk({sec, " rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({sec, " rsp_rdata"}, rsp_rdata, 32'h0);
    chk({sec, " rsp_err"}, 32'(rsp_err), 32'h0);
    chk({sec, " req_ready"}, 32'(req_ready), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge HCLK);
    apply(NO, NO);
    HRESETn = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    apply(RD(8'h00), RD(8'h04));
    repeat (2) @(negedge HCLK);
    #1 chk_reset("por");
    apply(NO, NO);
    HRESETn = 1'b1;

    // single write then read, port 0
    tbl.push_back(V(WR(8'h10, 32'hDEADBEEF, 3'd2), NO, 0, 0, R01, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h10), NO, 0, 0, R01, N, A(8'h10), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h10), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, A(8'h10), 2'b01, 32'h0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b01, 32'hDEADBEEF, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    run_tbl("wr_rd");

    // contention, pointer starts at port 0
    do_reset();
    tbl.push_back(V(RD(8'h20), RD(8'h40), 0, 0, R01, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h20), RD(8'h40), 0, 0, R10, N, A(8'h20), 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h20), RD(8'h40), 0, 0, R01, N, A(8'h40), 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h20), RD(8'h40), 0, 0, R10, N, A(8'h20), 2'b01, 32'hA0A0A0A0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h40), 2'b10, 32'hB0B0B0B0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b01, 32'hA0A0A0A0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b10, 32'hB0B0B0B0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    run_tbl("contend");

    // two-cycle stall in the data phase of the read of 0x08
    tbl.push_back(V(RD(8'h08), NO, 0, 0, R01, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(NO, RD(8'h0C), 0, 0, R10, N, A(8'h08), 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h10), NO, 1, 0, R00, N, A(8'h0C), 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h10), NO, 1, 0, R00, N, A(8'h0C), 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h10), NO, 0, 0, R01, N, A(8'h0C), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h10), 2'b01, 32'h08080808, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b10, 32'h0C0C0C0C, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b01, 32'hDEADBEEF, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    run_tbl("stall");

    // byte write into lane 3 of word 0, then read back
    tbl.push_back(V(NO, WR(8'h03, 32'hAAAAAAAA, 3'd0), 0, 0, R10, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h00), NO, 0, 0, R01, N, A(8'h03), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h00), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b10, 32'h0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b01, 32'hAA223344, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    run_tbl("byte");

    // ERROR on a write with a pipelined read behind it
    tbl.push_back(V(NO, WR(8'h30, 32'h55555555, 3'd2), 0, 0, R10, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(RD(8'h00), NO, 0, 0, R01, N, A(8'h30), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 1, R00, I, A(8'h00), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 2, R00, I, A(8'h00), 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h00), 2'b10, 32'h0, 1));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b01, 32'hAA223344, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, I, AX, 2'b00, 0, 0));
    run_tbl("error");

    // reset during the data phase of a halfword write from port 0
    tbl.push_back(V(WR(8'h34, 32'h56785678, 3'd1), NO, 0, 0, R01, I, AX, 2'b00, 0, 0));
    tbl.push_back(V(NO, NO, 0, 0, RX, N, A(8'h34), 2'b00, 0, 0));
    run_tbl("mid_rst");
    @(negedge HCLK);
    #1;
    chk("mid_rst data-phase hwdata", HWDATA, 32'h56785678);
    chk("mid_rst data-phase hsize", 32'(HSIZE), 32'h1);
    apply(RD(8'h00), RD(8'h04));
    #1 HRESETn = 1'b0;
    #1 chk_reset("mid_rst");
    apply(NO, NO);
    @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge HCLK);
      #1;
      chk($sformatf("mid_rst drop[%0d] rsp_valid", c), 32'(rsp_valid), 32'h0);
      chk($sformatf("mid_rst drop[%0d] htrans", c), 32'(HTRANS), 32'h0);
    end
    @(negedge HCLK);
    apply(RD(8'h00), RD(8'h04));
    #1 chk("mid_rst ptr req_ready", 32'(req_ready), 32'h1);
    @(negedge HCLK);
    apply(NO, NO);
    #1 chk("mid_rst reissue haddr", 32'(HADDR), 32'h0);
    repeat (3) @(negedge HCLK);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
